// File: rtl/da_interp_engine.sv
// Bit-serial distributed-arithmetic dot product of NTAPS signed samples with constant coefficients.
// Define DA_INTERP_SATURATE_EN to clamp the rounded result instead of wrapping it to OUT_W bits.
module da_interp_engine #(
  parameter int SAMPLE_W = 8,
  parameter int NTAPS = 2,
  parameter int COEF_W = 12,
  parameter logic [NTAPS*COEF_W-1:0] COEFS = {12'sd156, 12'sd100},
  parameter int OUT_W = 8,
  parameter int OUT_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      step_en,
  input  logic [NTAPS*SAMPLE_W-1:0] samples_in,
  output logic [OUT_W-1:0]          sample_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int LUT_W = COEF_W + $clog2(NTAPS) + 1;
  localparam int ACC_W = LUT_W + SAMPLE_W;
  localparam int SUM_W = ACC_W + OUT_W + 1;
  localparam int CNT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [SUM_W-1:0] RND = (OUT_SHIFT > 0) ? (SUM_W'(1'b1) << RND_SH) : '0;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  function automatic logic signed [LUT_W-1:0] lut_entry(input int unsigned k);
    logic signed [LUT_W-1:0] s;
    s = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (k[i]) s = s + LUT_W'($signed(COEFS[i*COEF_W +: COEF_W]));
      else      s = s;
    end
    return s;
  endfunction

  logic signed [LUT_W-1:0] lut_s [2**NTAPS];
  for (genvar k = 0; k < 2**NTAPS; k++) begin : g_lut
    assign lut_s[k] = lut_entry(k);
  end

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [NTAPS*SAMPLE_W-1:0]   smp_q, smp_d;
  logic [OUT_W-1:0]            sample_out_q, sample_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic [NTAPS-1:0]            lut_idx_s;
  logic signed [ACC_W-1:0]     term_s;
  logic signed [SUM_W-1:0]     rnd_sum_s;
  logic [OUT_W-1:0]            result_s;
`ifdef DA_INTERP_SATURATE_EN
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));
  logic signed [SUM_W-1:0]     r_s;
`endif

  // Gather the current bit of every tap and scale the table entry by its bit weight.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      lut_idx_s[i] = smp_q[i*SAMPLE_W + int'(cnt_q)];
    end
    term_s = ACC_W'(lut_s[lut_idx_s]) <<< cnt_q;
  end

  // Round half-up on the full-precision sum, then clamp or wrap into OUT_W bits.
  always_comb begin
    rnd_sum_s = SUM_W'(acc_q) + RND;
`ifdef DA_INTERP_SATURATE_EN
    r_s = rnd_sum_s >>> OUT_SHIFT;
    if (r_s > OUT_MAX)      result_s = OUT_MAX[OUT_W-1:0];
    else if (r_s < OUT_MIN) result_s = OUT_MIN[OUT_W-1:0];
    else                    result_s = r_s[OUT_W-1:0];
`else
    result_s = OUT_W'(rnd_sum_s >>> OUT_SHIFT);
`endif
  end

  // Next-state logic; a load always wins over a step and restarts from fresh samples.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    smp_d        = smp_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    overrun_d    = 1'b0;
    if (clk_en) begin
      state_d   = SHIFT;
      cnt_d     = '0;
      acc_d     = '0;
      smp_d     = samples_in;
      overrun_d = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SHIFT: begin
          if (step_en) begin
            // The MSB carries negative weight in two's complement.
            if (cnt_q == LAST_BIT) begin
              acc_d   = acc_q - term_s;
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              acc_d = acc_q + term_s;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          if (step_en) begin
            state_d      = IDLE;
            sample_out_d = result_s;
            out_valid_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      smp_q        <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      smp_q        <= smp_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_da_interp_engine.sv
// Randomized bench: five engine configurations share one stimulus stream and are checked every cycle.
module tb_da_interp_engine;

  localparam logic [11:0] C1 = 12'hA44;
  localparam logic [23:0] C2 = {12'd156, 12'd100};
  localparam logic [35:0] C3 = {12'h7FF, 12'h800, 12'h123};
  localparam logic [71:0] C6 = {12'h055, 12'hF00, 12'h3E8, 12'h801, 12'h7FF, 12'h00C};
  localparam logic [23:0] CS = {12'd2047, 12'd2047};
`ifdef DA_INTERP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic step_en = 1'b0;
  logic [47:0] smp = 48'd0;
  logic [7:0] sout [5];
  logic val [5];
  logic bsy [5];
  logic ovf [5];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int vcnt1 = 0;
  int ocnt1 = 0;

  always #5 clk = ~clk;

  da_interp_engine #(.NTAPS(1), .COEFS(C1), .OUT_SHIFT(0)) d1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .step_en(step_en), .samples_in(smp[7:0]),
    .sample_out(sout[0]), .out_valid(val[0]), .busy(bsy[0]), .overrun(ovf[0]));
  da_interp_engine d2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .step_en(step_en), .samples_in(smp[15:0]),
    .sample_out(sout[1]), .out_valid(val[1]), .busy(bsy[1]), .overrun(ovf[1]));
  da_interp_engine #(.NTAPS(3), .COEFS(C3)) d3 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .step_en(step_en), .samples_in(smp[23:0]),
    .sample_out(sout[2]), .out_valid(val[2]), .busy(bsy[2]), .overrun(ovf[2]));
  da_interp_engine #(.NTAPS(6), .COEFS(C6), .OUT_SHIFT(12)) d6 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .step_en(step_en), .samples_in(smp),
    .sample_out(sout[3]), .out_valid(val[3]), .busy(bsy[3]), .overrun(ovf[3]));
  da_interp_engine #(.COEFS(CS)) ds (
    .clk(clk), .reset(reset), .clk_en(clk_en), .step_en(step_en), .samples_in(smp[15:0]),
    .sample_out(sout[4]), .out_valid(val[4]), .busy(bsy[4]), .overrun(ovf[4]));

  function automatic logic [71:0] get_cf(input int k);
    case (k)
      0: return 72'(C1);
      1: return 72'(C2);
      2: return 72'(C3);
      3: return C6;
      default: return 72'(CS);
    endcase
  endfunction

  function automatic int get_nt(input int k);
    case (k)
      0: return 1;
      2: return 3;
      3: return 6;
      default: return 2;
    endcase
  endfunction

  function automatic int get_sh(input int k);
    case (k)
      0: return 0;
      3: return 12;
      default: return 8;
    endcase
  endfunction

  // Reference result: exact dot product, round half-up, arithmetic shift, then clamp or wrap.
  function automatic logic [7:0] ref_out(input logic [47:0] s, input int k);
    logic [71:0] c;
    longint y;
    longint r;
    c = get_cf(k);
    y = 0;
    for (int i = 0; i < get_nt(k); i++) begin
      y += longint'($signed(s[i*8 +: 8])) * longint'($signed(c[i*12 +: 12]));
    end
    if (get_sh(k) > 0) r = (y + (longint'(1) <<< (get_sh(k) - 1))) >>> get_sh(k);
    else r = y;
    if (SAT && r > 127) r = 127;
    else if (SAT && r < -128) r = -128;
    return r[7:0];
  endfunction

  // Transaction-level model: a load starts a job, SAMPLE_W+1 steps later the result appears.
  bit m_busy = 1'b0;
  int m_steps = 0;
  bit m_val = 1'b0;
  bit m_ovr = 1'b0;
  logic [47:0] m_cap = 48'd0;
  logic [7:0] m_out [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  always @(posedge clk) begin
    m_val <= 1'b0;
    m_ovr <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_steps <= 0;
      for (int k = 0; k < 5; k++) m_out[k] <= 8'd0;
    end else if (clk_en) begin
      m_ovr <= m_busy;
      m_busy <= 1'b1;
      m_steps <= 0;
      m_cap <= smp;
    end else if (step_en && m_busy) begin
      if (m_steps == 8) begin
        m_busy <= 1'b0;
        m_val <= 1'b1;
        for (int k = 0; k < 5; k++) m_out[k] <= ref_out(m_cap, k);
      end else begin
        m_steps <= m_steps + 1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 5; k++) begin
        chk("out_valid", k, 32'(val[k]), 32'(m_val));
        chk("sample_out", k, 32'(sout[k]), 32'(m_out[k]));
        chk("busy", k, 32'(bsy[k]), 32'(m_busy));
        chk("overrun", k, 32'(ovf[k]), 32'(m_ovr));
      end
      if (val[1]) vcnt1++;
      if (ovf[1]) ocnt1++;
    end
  end

  task automatic drive(input bit ce, input bit se, input bit rs, input logic [47:0] s);
    @(negedge clk);
    clk_en = ce;
    step_en = se;
    reset = rs;
    smp = s;
  endtask

  int v0;
  int o0;
  int cyc;
  logic [47:0] rs_smp;

  initial begin
    drive(1'b0, 1'b0, 1'b1, 48'd0);
    drive(1'b0, 1'b0, 1'b1, 48'd0);
    drive(1'b0, 1'b1, 1'b0, 48'd0);
    chk_en = 1'b1;
    chk("rst_sample_out", 1, 32'(sout[1]), 32'd0);
    chk("rst_busy", 1, 32'(bsy[1]), 32'd0);

    // x0=10, x1=20 -> y=4120 -> 16
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'd20, 8'd10});
    repeat (9) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("basic_valid", 1, 32'(val[1]), 32'd1);
    chk("basic_out", 1, 32'(sout[1]), 32'd16);

    // x0=x1=-128 -> -128
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'h80, 8'h80});
    repeat (9) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("neg_full_out", 1, 32'(sout[1]), 32'h80);

    // coefs 2047, x=127 -> clamp 127 or wrap 0xEF
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'd127, 8'd127});
    repeat (9) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("sat_valid", 4, 32'(val[4]), 32'd1);
    chk("sat_out", 4, 32'(sout[4]), SAT ? 32'd127 : 32'hEF);

    // Overrun: restart after 4 steps with x0=-3, x1=50 -> 29
    #1;
    v0 = vcnt1;
    o0 = ocnt1;
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'd127, 8'd127});
    repeat (4) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'd50, 8'hFD});
    drive(1'b0, 1'b1, 1'b0, smp);
    chk("overrun_pulse", 1, 32'(ovf[1]), 32'd1);
    repeat (8) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("overrun_out", 1, 32'(sout[1]), 32'd29);
    drive(1'b0, 1'b0, 1'b0, smp);
    #1;
    chk("overrun_one_valid", 1, 32'(vcnt1 - v0), 32'd1);
    chk("overrun_one_pulse", 1, 32'(ocnt1 - o0), 32'd1);

    // Load and step together: step ignored; x0=-50, x1=-7 -> -24
    drive(1'b1, 1'b1, 1'b0, {32'd0, 8'hF9, 8'hCE});
    repeat (8) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("no_early_valid", 1, 32'(val[1]), 32'd0);
    chk("still_busy", 1, 32'(bsy[1]), 32'd1);
    drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b0, 1'b0, smp);
    chk("late_valid", 1, 32'(val[1]), 32'd1);
    chk("late_out", 1, 32'(sout[1]), 32'hE8);

    // Reset during SHIFT
    drive(1'b1, 1'b0, 1'b0, {32'd0, 8'd5, 8'd5});
    repeat (3) drive(1'b0, 1'b1, 1'b0, smp);
    drive(1'b0, 1'b1, 1'b1, smp);
    drive(1'b0, 1'b1, 1'b0, smp);
    chk("mid_rst_busy", 1, 32'(bsy[1]), 32'd0);
    chk("mid_rst_out", 1, 32'(sout[1]), 32'd0);
    repeat (10) drive(1'b0, 1'b1, 1'b0, smp);

    // Random samples with gapped steps, occasional restarts and resets
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, smp);
      rs_smp = {$urandom, $urandom};
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, rs_smp);
      cyc = 0;
      do begin
        if ($urandom_range(0, 149) == 0) begin
          rs_smp = {$urandom, $urandom};
          drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, rs_smp);
        end else begin
          drive(1'b0, $urandom_range(0, 9) < 6, $urandom_range(0, 399) == 0, smp);
        end
        cyc++;
      end while (m_busy && cyc < 300);
      if (cyc >= 300) begin
        tests++;
        fails++;
        $display("FAIL txn_timeout[%0d] actual=%0d cycles required=<300", t, cyc);
      end
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, smp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/da_interp_engine.md
DA_INTERP_ENGINE -- requirements
Module: da_interp_engine

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 8: input sample width, signed two's complement.
REQ-002 The block SHALL have parameter NTAPS, default 2, legal range 1..6: number of taps summed per output.
REQ-003 The block SHALL have parameter COEF_W, default 12: signed coefficient width.
REQ-004 The block SHALL have parameter COEFS, default {12'sd156, 12'sd100}: packed NTAPS*COEF_W vector, with tap i in bits [i*COEF_W +: COEF_W].
REQ-005 The block SHALL have parameter OUT_W, default 8: signed output width.
REQ-006 The block SHALL have parameter OUT_SHIFT, default 8: right shift applied to the full-precision sum.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port clk_en, input, 1 bit: load strobe, which captures samples_in and starts a computation.
REQ-010 The block SHALL have port step_en, input, 1 bit: bit-step strobe, advancing one serial step per cycle in which it is high.
REQ-011 The block SHALL have port samples_in, input, NTAPS*SAMPLE_W bits: tap i sample in bits [i*SAMPLE_W +: SAMPLE_W].
REQ-012 The block SHALL have port sample_out, output, OUT_W bits: last completed result.
REQ-013 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-014 The block SHALL have port busy, output, 1 bit: high from load until the result is produced.
REQ-015 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when clk_en arrives while busy.

Function
REQ-016 The block SHALL compute y = sum over i of COEFS[i]*x[i] exactly, using distributed arithmetic.
  - Processing is bit-serial, LSB first, one bit of every tap per step_en.
  - The lookup table has 2^NTAPS entries; entry k = sum of COEFS[i] for each set bit i of k, computed at elaboration.
REQ-017 The step with bit index SAMPLE_W-1 (the MSB step) SHALL subtract the lookup-table entry; all other steps SHALL add it.
REQ-018 The accumulator SHALL be at least COEF_W+SAMPLE_W+clog2(NTAPS)+1 bits wide so that no intermediate overflow occurs.
REQ-019 Output rounding SHALL be r = (y + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, using an arithmetic shift; when OUT_SHIFT=0 no rounding term is added.
REQ-020 The block SHALL operate as a state machine with states IDLE, SHIFT and DONE.
  - IDLE --clk_en--> SHIFT, with the bit counter cleared and the accumulator cleared.
  - SHIFT: each step_en processes one bit; after SAMPLE_W steps the state goes to DONE.
  - DONE --step_en--> IDLE, writing sample_out and pulsing out_valid on the following cycle.
REQ-021 Latency SHALL be as follows: out_valid rises exactly 1 clk after the (SAMPLE_W+1)-th step_en following the load cycle, and step_en absence stalls the state machine indefinitely.
REQ-022 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-023 sample_out SHALL hold its value between out_valid pulses.
REQ-024 When clk_en and step_en are high in the same cycle, the load SHALL win and that step SHALL be ignored.
REQ-025 A clk_en received while busy SHALL abort the current computation and restart from the new samples, pulse overrun for 1 cycle, and produce no out_valid for the aborted computation.
REQ-026 A step_en received in IDLE SHALL be ignored.

Reset
REQ-027 When reset is high at a clk edge, the block SHALL go to IDLE and clear sample_out, out_valid, busy, overrun, the accumulator and the bit counter to 0.
REQ-028 Reset SHALL take priority over clk_en and step_en, and a reset mid-computation SHALL discard that computation with no out_valid.

Configuration
REQ-029 With DA_INTERP_SATURATE_EN defined, r SHALL be clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; without it, sample_out SHALL be r[OUT_W-1:0] (two's-complement wrap).

Verification
REQ-030 Default parameters, x0=10, x1=20, then 9 step_en -> out_valid, sample_out=16 (y=4120).
REQ-031 Default parameters, x0=x1=-128 -> sample_out=-128 (y=-32768).
REQ-032 COEFS={2047,2047}, x0=x1=127 -> sample_out=127 with DA_INTERP_SATURATE_EN defined, -17 (0xEF) without it.
REQ-033 clk_en again after 4 step_en -> overrun pulses once, exactly one out_valid occurs, and the result reflects only the second sample set.
REQ-034 clk_en and step_en together on the load cycle -> out_valid only after 9 further step_en; reset asserted during SHIFT -> busy=0 and sample_out=0 next cycle, with no out_valid.
REQ-035 step_en gapped randomly, compared against a reference model across 1000 random samples for NTAPS=1, 3 and 6 -> all outputs match.
